// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg                                                      |
// | Shared cache constants, arbiter state encoding and address mapping.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_arbiter_pkg;

    localparam int unsigned CACHE_LINE_W = 512;
    localparam int unsigned OFFSET_W     = 6;
    localparam int unsigned INDEX_W      = 7;
    localparam int unsigned REQ_ADDR_W   = 21;
    localparam int unsigned MEM_ADDR_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2,
        ST_FILL = 2'd3
    } arb_state_t;

    // Line address carries byte-address bits [26:6]; rebuild the full byte address.
    function automatic logic [MEM_ADDR_W-1:0] line_to_mem_addr(input logic [REQ_ADDR_W-1:0] line_addr);
        return {{(MEM_ADDR_W - REQ_ADDR_W - OFFSET_W){1'b0}}, line_addr, {OFFSET_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_grant_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_grant_sel                                                        |
// | Write-back / refill priority select with prog/data round-robin.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_grant_sel
    import mem_arbiter_pkg::*;
(
    input  logic main_clk,
    input  logic reset,
    input  logic advance,
    input  logic wb_pending,
    input  logic burst_below,
    input  logic elig_prog,
    input  logic elig_data,
    output logic grant_wb,
    output logic grant_prog,
    output logic grant_data
);

    logic r_rr_data;
    logic w_contend;

    assign w_contend = elig_prog && elig_data;

    always_comb begin
        grant_wb   = 1'b0;
        grant_prog = 1'b0;
        grant_data = 1'b0;
        if (wb_pending && burst_below) begin
            grant_wb = 1'b1;
        end else if (w_contend) begin
            grant_prog = !r_rr_data;
            grant_data = r_rr_data;
        end else if (elig_prog) begin
            grant_prog = 1'b1;
        end else if (elig_data) begin
            grant_data = 1'b1;
        end else if (wb_pending) begin
            grant_wb = 1'b1;
        end
    end

    // The pointer only moves on a real contention so prog wins the first one after reset.
    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            r_rr_data <= 1'b0;
        end else if (advance && w_contend && (grant_prog || grant_data)) begin
            r_rr_data <= grant_prog;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Arbitrates write-back FIFO and prog/data cache refills onto memory.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WB_BURST_MAX = 4,
    parameter int unsigned LINE_W       = CACHE_LINE_W
) (
    input  logic                  main_clk,
    input  logic                  reset,
    input  logic                  is_req_f_prog,
    input  logic [REQ_ADDR_W-1:0] req_addr_f_prog,
    input  logic                  is_req_f_data,
    input  logic [REQ_ADDR_W-1:0] req_addr_f_data,
    input  logic                  prog_line_full,
    input  logic                  data_line_full,
    input  logic                  fifo_empty,
    input  logic [31:0]           write_back_addr,
    input  logic [31:0]           write_back_data,
    output logic                  is_write_t_main,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_W-1:0]     mem_rdata,
    output logic                  is_write_prog_line,
    output logic [LINE_W-1:0]     read_main_prog_data,
    output logic [INDEX_W-1:0]    read_main_prog_addr,
    output logic                  is_write_data_line,
    output logic [LINE_W-1:0]     read_main_data_data,
    output logic [INDEX_W-1:0]    read_main_data_addr
);

    localparam int unsigned CNT_W = $clog2(WB_BURST_MAX + 1);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [31:0]           r_wb_addr;
    logic [31:0]           r_wb_data;
    logic                  r_sel_data;
    logic [REQ_ADDR_W-1:0] r_line_addr;
    logic [LINE_W-1:0]     r_line;
    logic                  r_served_prog;
    logic                  r_served_data;
    logic [REQ_ADDR_W-1:0] r_served_addr_prog;
    logic [REQ_ADDR_W-1:0] r_served_addr_data;
    logic [CNT_W-1:0]      r_burst;

    logic w_idle, w_fill, w_burst_below;
    logic w_hold_prog, w_hold_data, w_elig_prog, w_elig_data;
    logic w_grant_wb, w_grant_prog, w_grant_data, w_grant_rd;

    assign w_idle        = (r_state == ST_IDLE) && reset;
    assign w_fill        = (r_state == ST_FILL);
    assign w_burst_below = (r_burst < CNT_W'(WB_BURST_MAX));

    // A served flag only blocks while the same line is still being asked for.
    assign w_hold_prog = r_served_prog && is_req_f_prog && (req_addr_f_prog == r_served_addr_prog);
    assign w_hold_data = r_served_data && is_req_f_data && (req_addr_f_data == r_served_addr_data);
    assign w_elig_prog = is_req_f_prog && !w_hold_prog && !prog_line_full;
    assign w_elig_data = is_req_f_data && !w_hold_data && !data_line_full;
    assign w_grant_rd  = w_grant_prog || w_grant_data;

    mem_grant_sel u_grant_sel (
        .main_clk    (main_clk),
        .reset       (reset),
        .advance     (w_idle),
        .wb_pending  (!fifo_empty),
        .burst_below (w_burst_below),
        .elig_prog   (w_elig_prog),
        .elig_data   (w_elig_data),
        .grant_wb    (w_grant_wb),
        .grant_prog  (w_grant_prog),
        .grant_data  (w_grant_data)
    );

    always_comb begin
        w_next_state    = r_state;
        is_write_t_main = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_idle && w_grant_wb) begin
                    is_write_t_main = 1'b1;
                    w_next_state    = ST_WB;
                end else if (w_idle && w_grant_rd) begin
                    w_next_state = ST_RD;
                end
            end
            ST_WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = r_wb_addr;
                if (mem_ack) w_next_state = ST_IDLE;
            end
            ST_RD: begin
                mem_req  = 1'b1;
                mem_addr = line_to_mem_addr(r_line_addr);
                if (mem_ack) w_next_state = ST_FILL;
            end
            ST_FILL: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign mem_wdata           = r_wb_data;
    assign is_write_prog_line  = w_fill && !r_sel_data;
    assign is_write_data_line  = w_fill && r_sel_data;
    assign read_main_prog_data = r_line;
    assign read_main_data_data = r_line;
    assign read_main_prog_addr = r_line_addr[INDEX_W-1:0];
    assign read_main_data_addr = r_line_addr[INDEX_W-1:0];

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            r_state            <= ST_IDLE;
            r_wb_addr          <= '0;
            r_wb_data          <= '0;
            r_sel_data         <= 1'b0;
            r_line_addr        <= '0;
            r_line             <= '0;
            r_served_prog      <= 1'b0;
            r_served_data      <= 1'b0;
            r_served_addr_prog <= '0;
            r_served_addr_data <= '0;
            r_burst            <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_idle && w_grant_wb) begin
                r_wb_addr <= write_back_addr;
                r_wb_data <= write_back_data;
                if (w_burst_below) r_burst <= r_burst + CNT_W'(1);
            end
            if (w_idle && w_grant_rd) begin
                r_sel_data  <= w_grant_data;
                r_line_addr <= w_grant_data ? req_addr_f_data : req_addr_f_prog;
                r_burst     <= '0;
            end
            if ((r_state == ST_RD) && mem_ack) r_line <= mem_rdata;
            r_served_prog <= (w_fill && !r_sel_data) ? 1'b1 : w_hold_prog;
            r_served_data <= (w_fill && r_sel_data) ? 1'b1 : w_hold_data;
            if (w_fill && !r_sel_data) r_served_addr_prog <= r_line_addr;
            if (w_fill && r_sel_data) r_served_addr_data <= r_line_addr;
        end
    end

endmodule
`default_nettype wire
